// File: rtl/alu_arbiter_pkg.sv
// Shared constants for the ALU arbiter slice: datapath widths, ALU opcodes
// and the arbiter FSM state encoding.
package alu_arbiter_pkg;

  localparam int DATA_W = 8;
  localparam int OP_W   = 3;

  localparam logic [OP_W-1:0] OP_PASS = 3'b000;
  localparam logic [OP_W-1:0] OP_NOT  = 3'b001;
  localparam logic [OP_W-1:0] OP_ADD  = 3'b010;
  localparam logic [OP_W-1:0] OP_SUB  = 3'b011;
  localparam logic [OP_W-1:0] OP_AND  = 3'b100;
  localparam logic [OP_W-1:0] OP_OR   = 3'b101;
  localparam logic [OP_W-1:0] OP_NEG  = 3'b110;
  localparam logic [OP_W-1:0] OP_SHR  = 3'b111;

  // 2'b11 is unused and is steered back to S_IDLE by the FSM.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/alu.sv
// Existing 8-bit combinational ALU. All arithmetic wraps modulo 2^DATA_W,
// and the right shift is logical (zero fill).
module alu
  import alu_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] y,
  output logic              zero
);

  localparam logic [DATA_W-1:0] ONE = 1;

  // Opcode decode; every opcode produces a full-width result.
  always_comb begin
    y = '0;
    case (op)
      OP_PASS: y = a;
      OP_NOT:  y = ~a;
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NEG:  y = ~a + ONE;
      OP_SHR:  y = {1'b0, a[DATA_W-1:1]};
      default: y = '0;
    endcase
  end

  assign zero = (y == '0);

endmodule

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational round-robin picker: starting at ptr and walking upward with
// wrap-around, the first requester with req set wins.
module alu_arbiter_rr_pick #(
  parameter int NREQ = 2,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] win_oh,
  output logic [IW-1:0]   win_idx,
  output logic            any
);

  // Walk offsets from farthest to nearest so the nearest hit overwrites the
  // others and ends up as the winner.
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    any     = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      for (int j = 0; j < NREQ; j++) begin
        if (((j == int'(ptr) + k) || (j == int'(ptr) + k - NREQ)) && req[j]) begin
          win_oh    = '0;
          win_oh[j] = 1'b1;
          win_idx   = IW'(j);
          any       = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NREQ requesters. A round-robin pick in IDLE latches
// the winner's operands; EXEC registers the ALU result; DONE pulses done.
//
// Handshake: a requester holds req high with stable operands until it is
// sampled in IDLE. From then on the transaction is committed: gnt marks the
// owner through EXEC and DONE, and done pulses for one cycle in DONE with y
// and zero valid. Dropping req after the sample does not cancel anything.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [DATA_W*NREQ-1:0] a_bus,
  input  logic [DATA_W*NREQ-1:0] b_bus,
  input  logic [OP_W*NREQ-1:0]   op_bus,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        done,
  output logic [DATA_W-1:0]      y,
  output logic                   zero,
  output logic                   busy,
  output logic [1:0]             state_dbg
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t              state;
  state_t              state_nxt;
  logic [IW-1:0]       ptr;
  logic [IW-1:0]       win_idx;
  logic [NREQ-1:0]     win_oh;
  logic [DATA_W-1:0]   a_r;
  logic [DATA_W-1:0]   b_r;
  logic [OP_W-1:0]     op_r;
  logic [DATA_W-1:0]   y_r;
  logic                zero_r;

  logic [NREQ-1:0]     pick_oh;
  logic [IW-1:0]       pick_idx;
  logic                pick_any;
  logic [DATA_W-1:0]   a_sel;
  logic [DATA_W-1:0]   b_sel;
  logic [OP_W-1:0]     op_sel;
  logic [DATA_W-1:0]   alu_y;
  logic                alu_zero;

  alu_arbiter_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req     (req),
    .ptr     (ptr),
    .win_oh  (pick_oh),
    .win_idx (pick_idx),
    .any     (pick_any)
  );

  alu u_alu (
    .a    (a_r),
    .b    (b_r),
    .op   (op_r),
    .y    (alu_y),
    .zero (alu_zero)
  );

  // Operand mux for the requester the picker currently favours.
  always_comb begin
    a_sel  = '0;
    b_sel  = '0;
    op_sel = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (pick_oh[j]) begin
        a_sel  = a_bus[j*DATA_W +: DATA_W];
        b_sel  = b_bus[j*DATA_W +: DATA_W];
        op_sel = op_bus[j*OP_W +: OP_W];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state: one fixed pass IDLE -> EXEC -> DONE per transaction.
  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE:  state_nxt = pick_any ? S_EXEC : S_IDLE;
      S_EXEC:  state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand latch in IDLE, result capture in EXEC, pointer advance in DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr     <= '0;
      win_idx <= '0;
      a_r     <= '0;
      b_r     <= '0;
      op_r    <= '0;
      y_r     <= '0;
      zero_r  <= 1'b0;
    end else begin
      if (state == S_IDLE && pick_any) begin
        win_idx <= pick_idx;
        a_r     <= a_sel;
        b_r     <= b_sel;
        op_r    <= op_sel;
      end
      if (state == S_EXEC) begin
        y_r    <= alu_y;
        zero_r <= alu_zero;
      end
      if (state == S_DONE) begin
        ptr <= (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + IW'(1);
      end
    end
  end

  // Decode the latched winner index into a one-hot owner vector.
  always_comb begin
    win_oh = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (win_idx == IW'(j)) begin
        win_oh[j] = 1'b1;
      end
    end
  end

  // FSM outputs: gnt through EXEC/DONE, done only in DONE, busy off IDLE.
  always_comb begin
    gnt  = '0;
    done = '0;
    busy = 1'b0;
    case (state)
      S_EXEC: begin
        gnt  = win_oh;
        busy = 1'b1;
      end
      S_DONE: begin
        gnt  = win_oh;
        done = win_oh;
        busy = 1'b1;
      end
      default: begin
        gnt  = '0;
        done = '0;
        busy = 1'b0;
      end
    endcase
  end

  assign y         = y_r;
  assign zero      = zero_r;
  assign state_dbg = state;

endmodule
